// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY_IF = 2'b01,
        BUSY_DM = 2'b10
    } arb_state_t;

    localparam logic SEL_IF = 1'b0;
    localparam logic SEL_DM = 1'b1;

    // Width of the fairness counter that counts 0..max_grants.
    function automatic int fair_cnt_width(input int max_grants);
        return $clog2(max_grants + 1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant pick between eligible fetch and data requests.
// Data side wins unless it has used up its quota of grants while fetch waited.
module mem_arb_pick
    import unified_mem_arbiter_pkg::*;
#(
    parameter int MAX_DM_GRANTS = 2,
    parameter int CNT_W         = 2
) (
    input  logic             if_elig,
    input  logic             dm_elig,
    input  logic [CNT_W-1:0] fair_cnt,
    output logic             grant_valid,
    output logic             grant_sel
);

    localparam logic [CNT_W-1:0] FAIR_MAX = CNT_W'(MAX_DM_GRANTS);

    logic quota_spent;

    assign quota_spent = (fair_cnt == FAIR_MAX);

    always_comb begin
        grant_valid = if_elig | dm_elig;
        grant_sel   = SEL_IF;
        if (dm_elig && !(if_elig && quota_spent)) begin
            grant_sel = SEL_DM;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Serialises IF and DM accesses onto one single-port memory, one access in flight.
// Registered mem_* handshake; completion returns data with a one-cycle valid pulse.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int MAX_DM_GRANTS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              stall_if,
    output logic              stall_dm,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int               CNT_W    = fair_cnt_width(MAX_DM_GRANTS);
    localparam logic [CNT_W-1:0] FAIR_MAX = CNT_W'(MAX_DM_GRANTS);

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic [CNT_W-1:0] fair_cnt;
    logic             if_elig;
    logic             dm_elig;
    logic             grant_valid;
    logic             grant_sel;
    logic             grant_take;
    logic             done_if;
    logic             done_dm;

    // A requester whose valid is high still shows the request it just completed.
    assign if_elig  = if_req & ~if_valid;
    assign dm_elig  = dm_req & ~dm_valid;
    assign stall_if = if_req & ~if_valid;
    assign stall_dm = dm_req & ~dm_valid;

    mem_arb_pick #(
        .MAX_DM_GRANTS(MAX_DM_GRANTS),
        .CNT_W        (CNT_W)
    ) u_pick (
        .if_elig    (if_elig),
        .dm_elig    (dm_elig),
        .fair_cnt   (fair_cnt),
        .grant_valid(grant_valid),
        .grant_sel  (grant_sel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    if (grant_sel == SEL_DM) begin
                        state_d = BUSY_DM;
                    end else begin
                        state_d = BUSY_IF;
                    end
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // mem_ready only means something while an access is outstanding.
    always_comb begin
        grant_take = 1'b0;
        done_if    = 1'b0;
        done_dm    = 1'b0;
        case (state_q)
            IDLE:    grant_take = grant_valid;
            BUSY_IF: done_if    = mem_ready;
            BUSY_DM: done_dm    = mem_ready;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant_take) begin
            mem_req <= 1'b1;
            if (grant_sel == SEL_DM) begin
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
            end else begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end
        end else if (done_if || done_dm) begin
            mem_req <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            if_valid <= done_if;
            dm_valid <= done_dm;
            if (done_if) begin
                if_rdata <= mem_rdata;
            end
            if (done_dm && !mem_we) begin
                dm_rdata <= mem_rdata;
            end
        end
    end

    // Counts DM grants that made a waiting fetch lose; any fetch grant repays the debt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fair_cnt <= '0;
        end else if (grant_take) begin
            if (grant_sel == SEL_IF) begin
                fair_cnt <= '0;
            end else if (if_elig && fair_cnt != FAIR_MAX) begin
                fair_cnt <= fair_cnt + 1'b1;
            end
        end
    end

endmodule
